// File: rtl/regfile_cmd_sequencer_if.sv
// Command handshake plus register-file control/readback bundle for regfile_cmd_sequencer.
// slave = sequencer side, master = command issuer / register-file side.
interface regfile_cmd_sequencer_if;
    logic        CmdValid;
    logic        CmdReady;
    logic [2:0]  CmdOp;
    logic [2:0]  CmdDst;
    logic [2:0]  CmdSrc;
    logic [15:0] CmdData;
    logic        Done;
    logic [15:0] RespData;
    logic [15:0] RfI;
    logic [2:0]  RfOutASel;
    logic [2:0]  RfOutBSel;
    logic [2:0]  RfFunSel;
    logic [3:0]  RfRegSel;
    logic [3:0]  RfScrSel;
    logic [15:0] RfOutA;
    logic [15:0] RfOutB;

    modport slave (
        input  CmdValid, CmdOp, CmdDst, CmdSrc, CmdData, RfOutA, RfOutB,
        output CmdReady, Done, RespData, RfI, RfOutASel, RfOutBSel,
               RfFunSel, RfRegSel, RfScrSel
    );

    modport master (
        output CmdValid, CmdOp, CmdDst, CmdSrc, CmdData, RfOutA, RfOutB,
        input  CmdReady, Done, RespData, RfI, RfOutASel, RfOutBSel,
               RfFunSel, RfRegSel, RfScrSel
    );
endinterface

// File: rtl/regfile_cmd_sequencer.sv
// Turns one handshaked command at a time into register-file control cycles
// (load/clear/inc/dec, read, move, swap); all outputs are registered.
module regfile_cmd_sequencer #(
    parameter logic [2:0] FUN_DEC  = 3'b000,
    parameter logic [2:0] FUN_INC  = 3'b001,
    parameter logic [2:0] FUN_LOAD = 3'b010,
    parameter logic [2:0] FUN_CLR  = 3'b011
) (
    input  logic                     Clock,
    input  logic                     Reset,
    regfile_cmd_sequencer_if.slave   bus
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_EXEC = 3'd1;
    localparam logic [2:0] ST_RD   = 3'd2;
    localparam logic [2:0] ST_WR1  = 3'd3;
    localparam logic [2:0] ST_WR2  = 3'd4;
    localparam logic [2:0] ST_FIN  = 3'd5;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_LOAD  = 3'd1;
    localparam logic [2:0] OP_CLEAR = 3'd2;
    localparam logic [2:0] OP_INC   = 3'd3;
    localparam logic [2:0] OP_DEC   = 3'd4;
    localparam logic [2:0] OP_READ  = 3'd5;
    localparam logic [2:0] OP_MOVE  = 3'd6;
    localparam logic [2:0] OP_SWAP  = 3'd7;

    // {RegSel, ScrSel} with the single bit for index idx pulled low: R1 is bit 7, S4 is bit 0.
    function automatic logic [7:0] en_mask(input logic [2:0] idx);
        return ~(8'h80 >> idx);
    endfunction

    logic [2:0]  r_state;
    logic [2:0]  r_op;
    logic [2:0]  r_dst;
    logic [2:0]  r_src;
    logic [15:0] r_hold_b;
    logic        r_cmd_ready;
    logic        r_done;
    logic [15:0] r_resp;
    logic [15:0] r_rf_i;
    logic [2:0]  r_sel_a;
    logic [2:0]  r_sel_b;
    logic [2:0]  r_fun;
    logic [3:0]  r_reg_sel;
    logic [3:0]  r_scr_sel;

    logic        w_accept;

    assign w_accept = bus.CmdValid & r_cmd_ready;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_NOP;
            r_dst       <= '0;
            r_src       <= '0;
            r_hold_b    <= '0;
            r_cmd_ready <= 1'b1;
            r_done      <= 1'b0;
            r_resp      <= '0;
            r_rf_i      <= '0;
            r_sel_a     <= '0;
            r_sel_b     <= '0;
            r_fun       <= FUN_LOAD;
            r_reg_sel   <= '1;
            r_scr_sel   <= '1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op        <= bus.CmdOp;
                        r_dst       <= bus.CmdDst;
                        r_src       <= bus.CmdSrc;
                        r_cmd_ready <= 1'b0;
                        case (bus.CmdOp)
                            OP_READ, OP_MOVE: begin
                                r_state <= ST_RD;
                                r_sel_a <= bus.CmdSrc;
                            end
                            OP_SWAP: begin
                                r_state <= ST_RD;
                                r_sel_a <= bus.CmdSrc;
                                r_sel_b <= bus.CmdDst;
                            end
                            default: begin
                                r_state <= ST_EXEC;
                                r_rf_i  <= bus.CmdData;
                                case (bus.CmdOp)
                                    OP_CLEAR: r_fun <= FUN_CLR;
                                    OP_INC:   r_fun <= FUN_INC;
                                    OP_DEC:   r_fun <= FUN_DEC;
                                    default:  r_fun <= FUN_LOAD;
                                endcase
                                if (bus.CmdOp != OP_NOP)
                                    {r_reg_sel, r_scr_sel} <= en_mask(bus.CmdDst);
                            end
                        endcase
                    end
                end

                ST_EXEC: begin
                    r_state                <= ST_FIN;
                    r_done                 <= 1'b1;
                    r_fun                  <= FUN_LOAD;
                    r_rf_i                 <= '0;
                    {r_reg_sel, r_scr_sel} <= '1;
                end

                ST_RD: begin
                    r_resp  <= bus.RfOutA;
                    r_sel_a <= '0;
                    r_sel_b <= '0;
                    if (r_op == OP_READ) begin
                        r_state <= ST_FIN;
                        r_done  <= 1'b1;
                    end else begin
                        // RfI doubles as the A-side hold register for the dst write.
                        r_state                <= ST_WR1;
                        r_rf_i                 <= bus.RfOutA;
                        r_fun                  <= FUN_LOAD;
                        {r_reg_sel, r_scr_sel} <= en_mask(r_dst);
                        if (r_op == OP_SWAP)
                            r_hold_b <= bus.RfOutB;
                    end
                end

                ST_WR1: begin
                    if (r_op == OP_SWAP) begin
                        r_state                <= ST_WR2;
                        r_rf_i                 <= r_hold_b;
                        {r_reg_sel, r_scr_sel} <= en_mask(r_src);
                    end else begin
                        r_state                <= ST_FIN;
                        r_done                 <= 1'b1;
                        r_rf_i                 <= '0;
                        {r_reg_sel, r_scr_sel} <= '1;
                    end
                end

                ST_WR2: begin
                    r_state                <= ST_FIN;
                    r_done                 <= 1'b1;
                    r_rf_i                 <= '0;
                    {r_reg_sel, r_scr_sel} <= '1;
                end

                ST_FIN: begin
                    r_state     <= ST_IDLE;
                    r_done      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                end

                default: begin
                    r_state                <= ST_IDLE;
                    r_done                 <= 1'b0;
                    r_cmd_ready            <= 1'b1;
                    r_fun                  <= FUN_LOAD;
                    r_rf_i                 <= '0;
                    {r_reg_sel, r_scr_sel} <= '1;
                end
            endcase
        end
    end

    assign bus.CmdReady  = r_cmd_ready;
    assign bus.Done      = r_done;
    assign bus.RespData  = r_resp;
    assign bus.RfI       = r_rf_i;
    assign bus.RfOutASel = r_sel_a;
    assign bus.RfOutBSel = r_sel_b;
    assign bus.RfFunSel  = r_fun;
    assign bus.RfRegSel  = r_reg_sel;
    assign bus.RfScrSel  = r_scr_sel;

endmodule
